// File: rtl/fpu_pkg.sv
// Shared types and op codes for the FP command dispatcher.
package fpu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_SIN = 3'b011;
    localparam logic [2:0] OP_COS = 3'b100;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  op_sel;
    } fpu_cmd_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } fpu_state_e;

    // Codes above OP_COS have no wrapper operation behind them.
    function automatic logic op_legal(input logic [2:0] op_sel);
        return (op_sel <= OP_COS);
    endfunction

endpackage

// File: rtl/fpu_dispatch_if.sv
// Command, wrapper and result signals of the dispatcher; master is the environment side.
interface fpu_dispatch_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_op1;
    logic [31:0] cmd_op2;
    logic [2:0]  cmd_op_sel;

    logic [31:0] fpu_op1;
    logic [31:0] fpu_op2;
    logic [2:0]  fpu_op_sel;
    logic        fpu_op_strobe;
    logic [31:0] fpu_result;
    logic        fpu_done;
    logic        fpu_overflow;

    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_overflow;
    logic        res_err;
    logic        busy;

    modport master (
        output cmd_valid, cmd_op1, cmd_op2, cmd_op_sel,
        output fpu_result, fpu_done, fpu_overflow, res_ready,
        input  cmd_ready, fpu_op1, fpu_op2, fpu_op_sel, fpu_op_strobe,
        input  res_valid, res_data, res_overflow, res_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_op1, cmd_op2, cmd_op_sel,
        input  fpu_result, fpu_done, fpu_overflow, res_ready,
        output cmd_ready, fpu_op1, fpu_op2, fpu_op_sel, fpu_op_strobe,
        output res_valid, res_data, res_overflow, res_err, busy
    );

endinterface

// File: rtl/fpu_cmd_fifo.sv
// Small command FIFO; pointers wrap naturally, count carries one extra bit for full.
module fpu_cmd_fifo
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fpu_cmd_t                 wdata,
    input  logic                     pop,
    output fpu_cmd_t                 rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    fpu_cmd_t             mem_q [DEPTH];
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [PtrW:0]        count_q;
    logic                 push_ok;
    logic                 pop_ok;

    assign full    = (count_q == (PtrW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fpu_dispatch.sv
// Issues queued FP commands one at a time and returns a handshaked result.
module fpu_dispatch
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned MIN_WAIT = 2
) (
    input logic            clk,
    input logic            rst,
    fpu_dispatch_if.slave  bus
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    fpu_state_e            state_q, state_d;
    logic [CntW-1:0]       wait_cnt_q, wait_cnt_d;
    fpu_cmd_t              cmd_q, cmd_d;
    logic [31:0]           res_data_q, res_data_d;
    logic                  res_ovf_q, res_ovf_d;
    logic                  res_err_q, res_err_d;

    fpu_cmd_t              head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  push;
    logic                  pop;

    assign push = bus.cmd_valid & ~fifo_full;

    fpu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({bus.cmd_op1, bus.cmd_op2, bus.cmd_op_sel}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state, pop and result capture for the single in-flight op.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        cmd_d      = cmd_q;
        res_data_d = res_data_q;
        res_ovf_d  = res_ovf_q;
        res_err_d  = res_err_q;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                // res_valid is only set in StDone, so an idle pop never overwrites a result.
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    cmd_d = head;
                    if (op_legal(head.op_sel)) begin
                        state_d = StIssue;
                    end else begin
                        res_data_d = '0;
                        res_ovf_d  = 1'b0;
                        res_err_d  = 1'b1;
                        state_d    = StDone;
                    end
                end
            end
            StIssue: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // Early cycles are masked so a done level left over from the last op is ignored.
                if (wait_cnt_q >= CntW'(MIN_WAIT) && bus.fpu_done) begin
                    res_data_d = bus.fpu_result;
                    res_ovf_d  = bus.fpu_overflow;
                    res_err_d  = 1'b0;
                    state_d    = StDone;
                end else if (wait_cnt_q == CntW'(TIMEOUT - 1)) begin
                    res_data_d = '0;
                    res_ovf_d  = 1'b0;
                    res_err_d  = 1'b1;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (bus.res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, timer, held operands and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            cmd_q      <= '0;
            res_data_q <= '0;
            res_ovf_q  <= 1'b0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cmd_q      <= cmd_d;
            res_data_q <= res_data_d;
            res_ovf_q  <= res_ovf_d;
            res_err_q  <= res_err_d;
        end
    end

    assign bus.cmd_ready     = ~fifo_full;
    assign bus.fpu_op1       = cmd_q.op1;
    assign bus.fpu_op2       = cmd_q.op2;
    assign bus.fpu_op_sel    = cmd_q.op_sel;
    assign bus.fpu_op_strobe = (state_q == StIssue);
    assign bus.res_valid     = (state_q == StDone);
    assign bus.res_data      = res_data_q;
    assign bus.res_overflow  = res_ovf_q;
    assign bus.res_err       = res_err_q;
    assign bus.busy          = (fifo_count != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed and random checks of fpu_dispatch against a wrapper model and result scoreboard.
module tb_fpu_dispatch;
    import fpu_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned TIMEOUT  = 64;
    localparam int unsigned MIN_WAIT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fpu_dispatch_if bus ();

    fpu_dispatch #(
        .DEPTH    (DEPTH),
        .TIMEOUT  (TIMEOUT),
        .MIN_WAIT (MIN_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int strobes = 0;
    int exp_strobes = 0;
    int lat_q[$];
    logic [33:0] exp_q[$];

    // Single-precision helpers via double-precision reals (normals only, truncating).
    function automatic real sp2r(input logic [31:0] a);
        logic [10:0] e;
        if (a[30:23] == 8'd0) return 0.0;
        e = {3'b000, a[30:23]} + 11'd896;
        return $bitstoreal({a[31], e, a[22:0], 29'b0});
    endfunction

    function automatic logic [31:0] r2sp(input real r, output logic ovf);
        logic [63:0] b;
        int e;
        b   = $realtobits(r);
        ovf = 1'b0;
        e   = int'({21'b0, b[62:52]}) - 896;
        if (b[62:52] == 11'd0) return {b[63], 31'b0};
        if (e >= 255) begin
            ovf = 1'b1;
            return {b[63], 8'hFF, 23'b0};
        end
        if (e <= 0) return {b[63], 31'b0};
        return {b[63], 8'(e), b[51:29]};
    endfunction

    function automatic logic [31:0] fp_calc(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] sel, output logic ovf);
        real x, y, r;
        x = sp2r(a);
        y = sp2r(b);
        case (sel)
            3'd0:    r = x + y;
            3'd1:    r = x - y;
            3'd2:    r = x * y;
            3'd3:    r = $sin(x);
            default: r = $cos(x);
        endcase
        return r2sp(r, ovf);
    endfunction

    // Wrapper model: after a strobe, raises done (a held level) after the op's latency; 0 = never.
    logic [31:0] w_a = '0, w_b = '0, w_res = '0;
    logic [2:0]  w_sel = '0;
    logic        w_done = 1'b0, w_ovf = 1'b0, w_armed = 1'b0;
    int          w_cnt = 0;

    assign bus.fpu_result   = w_res;
    assign bus.fpu_done     = w_done;
    assign bus.fpu_overflow = w_ovf;

    // Model reacts to strobes and counts them.
    always @(posedge clk) begin
        int l;
        logic [31:0] r;
        logic o;
        if (bus.fpu_op_strobe) begin
            l = 5;
            if (lat_q.size() > 0) l = lat_q.pop_front();
            w_cnt   <= l;
            w_armed <= 1'b1;
            w_a     <= bus.fpu_op1;
            w_b     <= bus.fpu_op2;
            w_sel   <= bus.fpu_op_sel;
            strobes <= strobes + 1;
        end else if (w_armed) begin
            if (w_cnt == 0) begin
                w_done <= 1'b0;
            end else if (w_cnt <= 1) begin
                r = fp_calc(w_a, w_b, w_sel, o);
                w_res   <= r;
                w_ovf   <= o;
                w_done  <= 1'b1;
                w_armed <= 1'b0;
            end else begin
                w_cnt  <= w_cnt - 1;
                w_done <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one command, wait (bounded) for acceptance and record its expected outcome.
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                        input int lat);
        int n;
        logic o;
        logic [31:0] d;
        n = 0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_op1    = a;
        bus.cmd_op2    = b;
        bus.cmd_op_sel = sel;
        while (!bus.cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", 64'(n < 300), 64'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (sel <= 3'd4) begin
            lat_q.push_back(lat);
            exp_strobes++;
            if (lat == 0 || lat >= int'(TIMEOUT)) begin
                exp_q.push_back({32'h0, 1'b0, 1'b1});
            end else begin
                d = fp_calc(a, b, sel, o);
                exp_q.push_back({d, o, 1'b0});
            end
        end else begin
            exp_q.push_back({32'h0, 1'b0, 1'b1});
        end
    endtask

    // Accept one result (bounded wait) and compare it with the oldest expectation.
    task automatic drain(input string tag, output logic [33:0] got);
        int n;
        logic [33:0] e;
        n = 0;
        bus.res_ready = 1'b1;
        while (!bus.res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 64'(bus.res_valid), 64'd1);
        got = {bus.res_data, bus.res_overflow, bus.res_err};
        e = '1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk(tag, 64'(got), 64'(e));
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_sp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    initial begin
        logic [33:0] got, first;
        int n, s0;
        bit seen;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op1    = '0;
        bus.cmd_op2    = '0;
        bus.cmd_op_sel = '0;
        bus.res_ready  = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_strobe", 64'(bus.fpu_op_strobe), 64'd0);
        chk("rst_outs", {bus.fpu_op1, bus.res_data}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single multiply.
        s0 = strobes;
        push(32'h3FA00000, 32'h3FC00000, OP_MUL, 5);
        drain("t1_mul", got);
        chk("t1_const", 64'(got), 64'({32'h3FF00000, 1'b0, 1'b0}));
        chk("t1_strobes", 64'(strobes - s0), 64'd1);

        // 2: back-to-back add then multiply, in order.
        s0 = strobes;
        push(32'h40200000, 32'h40600000, OP_ADD, 3);
        push(32'h40000000, 32'h40400000, OP_MUL, 7);
        drain("t2_add", got);
        chk("t2_add_const", 64'(got[33:2]), 64'h40C00000);
        drain("t2_mul", got);
        chk("t2_mul_const", 64'(got[33:2]), 64'h40C00000);
        chk("t2_strobes", 64'(strobes - s0), 64'd2);

        // 3: fill FIFO behind a stalled result, then drain in order.
        for (int i = 0; i < 5; i++) push(32'h3F800000 + 32'(i << 20), 32'h40000000, OP_ADD, 4);
        chk("t3_full", 64'(bus.cmd_ready), 64'd0);
        chk("t3_busy", 64'(bus.busy), 64'd1);
        n = 0;
        while (!bus.res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        first = {bus.res_data, bus.res_overflow, bus.res_err};
        repeat (3) @(negedge clk);
        chk("t3_hold", 64'({bus.res_valid, bus.res_data, bus.res_overflow, bus.res_err}),
            64'({1'b1, first}));
        for (int i = 0; i < 5; i++) drain("t3_drain", got);

        // 4: illegal op, no strobe, quick error.
        s0 = strobes;
        push(32'h12345678, 32'h9ABCDEF0, 3'b111, 5);
        n = 0;
        while (!bus.res_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t4_fast", 64'(n <= 2), 64'd1);
        drain("t4_illegal", got);
        chk("t4_nostrobe", 64'(strobes - s0), 64'd0);

        // 5: wrapper never answers; next queued command proceeds.
        push(32'h3F800000, 32'h3F800000, OP_ADD, 0);
        push(32'h40400000, 32'h40000000, OP_SUB, 6);
        n = 0;
        while (!bus.res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_window", 64'(n >= int'(TIMEOUT) && n <= int'(TIMEOUT) + 4), 64'd1);
        drain("t5_timeout", got);
        drain("t5_next", got);
        chk("t5_next_const", 64'(got), 64'({32'h3F800000, 1'b0, 1'b0}));

        // Timeout boundary: done on the last wait cycle wins, one later loses.
        push(32'h3FC00000, 32'h40000000, OP_MUL, int'(TIMEOUT) - 1);
        drain("late_ok", got);
        push(32'h3FC00000, 32'h40000000, OP_MUL, int'(TIMEOUT));
        drain("too_late", got);

        // Overflow passes through.
        push(32'h7F000000, 32'h7F000000, OP_MUL, 4);
        drain("ovf", got);
        chk("ovf_flag", 64'(got[1]), 64'd1);

        // 6: reset during WAIT drops the op and the queue; stale done ignored afterwards.
        s0 = strobes;
        push(32'h41200000, 32'h41200000, OP_MUL, 30);
        push(32'h3F800000, 32'h3F800000, OP_ADD, 5);
        n = 0;
        while (strobes == s0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(bus.res_valid), 64'd0);
        chk("t6_rst_busy", 64'(bus.busy), 64'd0);
        chk("t6_rst_ready", 64'(bus.cmd_ready), 64'd1);
        chk("t6_rst_ops", {bus.fpu_op1, 29'd0, bus.fpu_op_sel}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        lat_q.delete();
        exp_strobes--;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1'b1;
        end
        chk("t6_no_result", 64'(seen), 64'd0);
        push(32'h40000000, 32'h40400000, OP_ADD, 5);
        drain("t6_restart", got);
        chk("t6_restart_const", 64'(got), 64'({32'h40A00000, 1'b0, 1'b0}));

        // Random mix with random consumer pacing.
        for (int i = 0; i < 24; i++) begin
            logic [2:0] sel;
            int lat;
            sel = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            lat = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(2, 20));
            push(rand_sp(), rand_sp(), sel, lat);
            if (exp_q.size() >= DEPTH + 1 || $urandom_range(0, 2) == 0) drain("rnd", got);
        end
        while (exp_q.size() > 0) drain("rnd_tail", got);
        chk("strobe_total", 64'(strobes), 64'(exp_strobes));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
